rtc_bus_sequencer: RTL and testbench

// - Drives the multiplexed address/data bus of the external RTC (V3023-class) for the PicoBlaze register bank.
// - Consumes the bank's latched fields (year..st), write strobe and timer-only flag.
// - Returns read-back bytes plus a one-cycle completion pulse: fields *le and Listo_es.
// - Serialises 9 byte transactions: address phase, then data phase, with programmable strobe widths.

---
 rtl/rtc_pkg.sv | 47 ++++
 rtl/rtc_phase_timer.sv | 26 ++
 rtl/rtc_bus_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the V3023-class RTC bus sequencer: FSM encoding,
// field count, register address table and transfer command codes.
package rtc_pkg;

  localparam int unsigned NUM_FIELDS      = 9;
  localparam int unsigned TIMER_FIRST_IDX = 6;
  localparam logic [7:0]  CMD_READ        = 8'hF0;
  localparam logic [7:0]  CMD_WRITE       = 8'hF1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StGap1,
    StData,
    StGap2,
    StDone
  } state_e;

  // RTC register address for field index 0..8 (ano .. st).
  function automatic logic [7:0] field_addr(input logic [3:0] idx);
    logic [7:0] addr;
    case (idx)
      4'd0:    addr = 8'h26;
      4'd1:    addr = 8'h25;
      4'd2:    addr = 8'h24;
      4'd3:    addr = 8'h23;
      4'd4:    addr = 8'h22;
      4'd5:    addr = 8'h21;
      4'd6:    addr = 8'h43;
      4'd7:    addr = 8'h42;
      4'd8:    addr = 8'h41;
      default: addr = 8'h00;
    endcase
    return addr;
  endfunction

  // Extract byte idx from the packed 9-byte field vector ([7:0] = idx0).
  function automatic logic [7:0] field_byte(input logic [71:0] v, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (idx == 4'(i)) b = v[i*8 +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that times each bus phase; o_zero marks the
// last cycle of the phase.
module rtc_phase_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Reload on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for the external RTC. Serialises
// up to 9 byte transactions (address phase, gap, data phase, gap) per
// write or read request and pulses o_done at the end.
// Optional feature macro: RTC_CMD_TRANSFER_EN adds an F0/F0 command before
// each read sequence and an F1/F1 command after each write sequence.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_GAP   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_write,
  input  logic        i_timer_only,
  input  logic        i_start_read,
  input  logic [71:0] i_wr_data,
  output logic [71:0] o_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_cs_n,
  output logic        o_ad_sel,
  output logic        o_wr_n,
  output logic        o_rd_n,
  output logic [7:0]  o_ad_out,
  output logic        o_ad_oe,
  input  logic [7:0]  i_ad_in
);

`ifdef RTC_CMD_TRANSFER_EN
  localparam bit CmdEn = 1'b1;
`else
  localparam bit CmdEn = 1'b0;
`endif

  state_e      r_state, w_state_d;
  logic [3:0]  r_idx, w_idx_d;
  logic        r_is_read, w_is_read_d;
  logic        r_cmd, w_cmd_d;
  logic        r_pend_wr, w_pend_wr_d;
  logic        r_pend_timer, w_pend_timer_d;
  logic        r_pend_rd, w_pend_rd_d;
  logic [7:0]  r_wbyte, w_wbyte_d;
  logic [71:0] r_rd_data, w_rd_data_d;
  logic        w_timer;
  logic        w_load;
  logic [7:0]  w_load_val;
  logic        w_zero;
  logic [7:0]  w_addr;
  logic [7:0]  w_wdata;
  logic        w_drive_data;

  rtc_phase_timer u_phase_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  // State, index, pending flags and read-back register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_idx        <= 4'd0;
      r_is_read    <= 1'b0;
      r_cmd        <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_timer <= 1'b0;
      r_pend_rd    <= 1'b0;
      r_wbyte      <= 8'h00;
      r_rd_data    <= 72'h0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_is_read    <= w_is_read_d;
      r_cmd        <= w_cmd_d;
      r_pend_wr    <= w_pend_wr_d;
      r_pend_timer <= w_pend_timer_d;
      r_pend_rd    <= w_pend_rd_d;
      r_wbyte      <= w_wbyte_d;
      r_rd_data    <= w_rd_data_d;
    end
  end

  // Next-state: arbitration, phase sequencing and read-back capture.
  always_comb begin
    w_state_d      = r_state;
    w_idx_d        = r_idx;
    w_is_read_d    = r_is_read;
    w_cmd_d        = r_cmd;
    w_pend_wr_d    = r_pend_wr;
    w_pend_timer_d = r_pend_timer;
    w_pend_rd_d    = r_pend_rd;
    w_wbyte_d      = r_wbyte;
    w_rd_data_d    = r_rd_data;
    w_timer        = 1'b0;
    w_load         = 1'b0;
    w_load_val     = 8'd0;

    // Requests arriving while a sequence runs are parked; repeats are dropped.
    if (r_state != StIdle) begin
      if (i_start_write && !r_pend_wr) begin
        w_pend_wr_d    = 1'b1;
        w_pend_timer_d = i_timer_only;
      end
      if (i_start_read) w_pend_rd_d = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (r_pend_wr || i_start_write) begin
          w_timer     = r_pend_wr ? r_pend_timer : i_timer_only;
          w_state_d   = StAddr;
          w_is_read_d = 1'b0;
          w_cmd_d     = 1'b0;
          w_idx_d     = w_timer ? 4'(TIMER_FIRST_IDX) : 4'd0;
          w_pend_wr_d = 1'b0;
          if (i_start_read) w_pend_rd_d = 1'b1;
        end else if (r_pend_rd || i_start_read) begin
          w_state_d   = StAddr;
          w_is_read_d = 1'b1;
          w_cmd_d     = CmdEn;
          w_idx_d     = 4'd0;
          w_pend_rd_d = 1'b0;
        end
      end
      StAddr: if (w_zero) w_state_d = StGap1;
      StGap1: if (w_zero) w_state_d = StData;
      StData: begin
        if (w_zero) begin
          w_state_d = StGap2;
          if (r_is_read && !r_cmd) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
              if (r_idx == 4'(i)) w_rd_data_d[i*8 +: 8] = i_ad_in;
            end
          end
        end
      end
      StGap2: begin
        if (w_zero) begin
          if (r_cmd) begin
            // Read command leads the fields; write command trails them.
            if (r_is_read) begin
              w_cmd_d   = 1'b0;
              w_idx_d   = 4'd0;
              w_state_d = StAddr;
            end else begin
              w_state_d = StDone;
            end
          end else if (r_idx == 4'(NUM_FIELDS - 1)) begin
            if (!r_is_read && CmdEn) begin
              w_cmd_d   = 1'b1;
              w_state_d = StAddr;
            end else begin
              w_state_d = StDone;
            end
          end else begin
            w_idx_d   = r_idx + 4'd1;
            w_state_d = StAddr;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_state_d != r_state) begin
      w_load     = 1'b1;
      w_load_val = (w_state_d == StGap1 || w_state_d == StGap2) ? 8'(T_GAP - 1)
                                                                : 8'(T_PULSE - 1);
    end
    if (w_state_d == StAddr && r_state != StAddr) begin
      w_wbyte_d = field_byte(i_wr_data, w_idx_d);
    end
  end

  assign w_addr       = r_cmd ? (r_is_read ? CMD_READ : CMD_WRITE) : field_addr(r_idx);
  assign w_wdata      = r_cmd ? w_addr : r_wbyte;
  assign w_drive_data = !r_is_read || r_cmd;

  // Bus pins decoded from the current phase.
  always_comb begin
    o_cs_n   = 1'b1;
    o_ad_sel = 1'b0;
    o_wr_n   = 1'b1;
    o_rd_n   = 1'b1;
    o_ad_oe  = 1'b0;
    o_ad_out = 8'h00;
    unique case (r_state)
      StAddr: begin
        o_cs_n   = 1'b0;
        o_wr_n   = 1'b0;
        o_ad_oe  = 1'b1;
        o_ad_out = w_addr;
      end
      StGap1: begin
        o_cs_n   = 1'b0;
        o_ad_oe  = 1'b1;
        o_ad_out = w_addr;
      end
      StData: begin
        o_cs_n   = 1'b0;
        o_ad_sel = 1'b1;
        if (w_drive_data) begin
          o_wr_n   = 1'b0;
          o_ad_oe  = 1'b1;
          o_ad_out = w_wdata;
        end else begin
          o_rd_n = 1'b0;
        end
      end
      StGap2: begin
        o_cs_n   = 1'b0;
        o_ad_sel = 1'b1;
        o_ad_oe  = w_drive_data;
        o_ad_out = w_drive_data ? w_wdata : 8'h00;
      end
      default: begin
      end
    endcase
  end

  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StDone);
  assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: stimulus pushes the expected bus
// transactions and completion records; a negedge monitor decodes the bus,
// acts as the RTC for reads and pops/compares.
module tb_rtc_bus_sequencer;

  localparam int unsigned TP  = 4;
  localparam int unsigned TG  = 2;
  localparam int unsigned PER = 2 * (TP + TG);
`ifdef RTC_CMD_TRANSFER_EN
  localparam bit CmdEn = 1'b1;
`else
  localparam bit CmdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_write = 1'b0;
  logic        timer_only = 1'b0;
  logic        start_read = 1'b0;
  logic [71:0] wr_data = 72'h0;
  logic [7:0]  ad_in = 8'h00;
  logic [71:0] rd_data;
  logic        busy, done, cs_n, ad_sel, wr_n, rd_n, ad_oe;
  logic [7:0]  ad_out;

  rtc_bus_sequencer #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .i_clk         (clk),
    .i_reset       (reset_n),
    .i_start_write (start_write),
    .i_timer_only  (timer_only),
    .i_start_read  (start_read),
    .i_wr_data     (wr_data),
    .o_rd_data     (rd_data),
    .o_busy        (busy),
    .o_done        (done),
    .o_cs_n        (cs_n),
    .o_ad_sel      (ad_sel),
    .o_wr_n        (wr_n),
    .o_rd_n        (rd_n),
    .o_ad_out      (ad_out),
    .o_ad_oe       (ad_oe),
    .i_ad_in       (ad_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [7:0]  data;
    bit          rd;
    int          cyc;
    logic [71:0] rdd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  key = 8'hFF;
  logic [71:0] exp_rd = 72'h0;
  logic [7:0]  addr_tab [9] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected bus traffic and completion for one sequence accepted at edge acc.
  task automatic push_seq(input bit rd, input bit tmr, input int acc, output int next_acc);
    exp_t e;
    int   n = 0;
    int   first = (!rd && tmr) ? 6 : 0;
    e = '{is_done: 1'b0, addr: 8'h00, data: 8'h00, rd: 1'b0, cyc: 0, rdd: 72'h0};
    if (rd && CmdEn) begin
      e.addr = 8'hF0; e.data = 8'hF0; e.rd = 1'b0;
      q.push_back(e); n++;
    end
    for (int i = first; i < 9; i++) begin
      e.addr = addr_tab[i];
      e.data = rd ? 8'h00 : wr_data[i*8 +: 8];
      e.rd   = rd;
      q.push_back(e); n++;
    end
    if (!rd && CmdEn) begin
      e.addr = 8'hF1; e.data = 8'hF1; e.rd = 1'b0;
      q.push_back(e); n++;
    end
    if (rd) begin
      for (int i = 0; i < 9; i++) exp_rd[i*8 +: 8] = addr_tab[i] ^ key;
    end
    e.is_done = 1'b1;
    e.cyc     = acc + int'(PER) * n;
    e.rdd     = exp_rd;
    q.push_back(e);
    next_acc = e.cyc + 2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit w, input bit t, input bit r);
    start_write = w;
    timer_only  = t;
    start_read  = r;
    tick();
    start_write = 1'b0;
    timer_only  = 1'b0;
    start_read  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || busy) && n < 5000) begin
      tick();
      n++;
    end
    check(name, 72'(q.size() == 0 && !busy), 72'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 72'(cs_n), 72'd1);
    check({tag, "_wr_n"}, 72'(wr_n), 72'd1);
    check({tag, "_rd_n"}, 72'(rd_n), 72'd1);
    check({tag, "_busy"}, 72'(busy), 72'd0);
    check({tag, "_done"}, 72'(done), 72'd0);
    check({tag, "_ad_oe"}, 72'(ad_oe), 72'd0);
    check({tag, "_ad_sel"}, 72'(ad_sel), 72'd0);
    check({tag, "_ad_out"}, 72'(ad_out), 72'd0);
    check({tag, "_rd_data"}, rd_data, 72'h0);
  endtask

  // Bus monitor and RTC model.
  initial begin
    int         lo_cnt = 0;
    int         gap_cnt = 0;
    bit         have_prev = 1'b0;
    bit         cur_sel = 1'b0;
    bit         cur_rd = 1'b0;
    bit         val_ok = 1'b1;
    bit         oe_ok = 1'b1;
    logic [7:0] cur_val = 8'h00;
    logic [7:0] last_addr = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        lo_cnt = 0; gap_cnt = 0; have_prev = 1'b0;
        ad_in = 8'($urandom);
      end else begin
        if (!wr_n || !rd_n) begin
          if (lo_cnt == 0) begin
            if (have_prev) check("gap_width", 72'(gap_cnt), 72'(TG));
            cur_sel = ad_sel;
            cur_rd  = !rd_n;
            cur_val = ad_out;
            val_ok  = 1'b1;
            oe_ok   = 1'b1;
          end
          lo_cnt++;
          if (!cur_rd && ad_out != cur_val) val_ok = 1'b0;
          if (ad_oe !== !cur_rd) oe_ok = 1'b0;
          // Only the final read-strobe cycle carries the real register value.
          ad_in = (cur_rd && lo_cnt == int'(TP)) ? (last_addr ^ key) : 8'($urandom);
          gap_cnt = 0;
        end else begin
          if (lo_cnt != 0) begin
            check("strobe_width", 72'(lo_cnt), 72'(TP));
            check("strobe_ad_oe", 72'(oe_ok), 72'd1);
            check("strobe_ad_out_stable", 72'(val_ok), 72'd1);
            if (!cur_sel) begin
              last_addr = cur_val;
            end else if (q.size() == 0) begin
              check("unexpected_transaction", 72'(q.size()), 72'd1);
            end else begin
              e = q.pop_front();
              check("trans_kind", 72'(e.is_done), 72'd0);
              check("trans_addr", 72'(last_addr), 72'(e.addr));
              check("trans_dir", 72'(cur_rd), 72'(e.rd));
              if (!e.rd) check("trans_data", 72'(cur_val), 72'(e.data));
            end
            lo_cnt = 0;
            have_prev = 1'b1;
          end
          if (cs_n) have_prev = 1'b0;
          else gap_cnt++;
          ad_in = 8'($urandom);
        end
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 72'(q.size()), 72'd1);
          end else begin
            e = q.pop_front();
            check("done_kind", 72'(e.is_done), 72'd1);
            check("done_cycle", 72'(cyc), 72'(e.cyc));
            check("done_rd_data", rd_data, e.rdd);
            check("done_busy", 72'(busy), 72'd1);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nx, nx2, nx3, n;
    bit found;

    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Directed full write: bytes idx0..8 = 16,15,14,13,12,11,07,06,05.
    wr_data = 72'h05_06_07_11_12_13_14_15_16;
    acc = cyc + 1;
    push_seq(1'b0, 1'b0, acc, nx);
    pulse(1'b1, 1'b0, 1'b0);
    wait_drain("drain_write");

    // Directed read with the RTC answering address ^ FF.
    key = 8'hFF;
    acc = cyc + 1;
    push_seq(1'b1, 1'b0, acc, nx);
    pulse(1'b0, 1'b0, 1'b1);
    wait_drain("drain_read");
    check("read_idx0", 72'(rd_data[7:0]), 72'hD9);
    check("read_idx8", 72'(rd_data[71:64]), 72'hBE);

    // Timer-only write.
    wr_data = {$urandom, $urandom, $urandom};
    acc = cyc + 1;
    push_seq(1'b0, 1'b1, acc, nx);
    pulse(1'b1, 1'b1, 1'b0);
    wait_drain("drain_timer");

    // Simultaneous write and read: write first, read follows after one idle cycle.
    key = 8'($urandom);
    acc = cyc + 1;
    push_seq(1'b0, 1'b0, acc, nx);
    push_seq(1'b1, 1'b0, nx, nx2);
    pulse(1'b1, 1'b0, 1'b1);
    wait_drain("drain_both");

    // Requests while busy, with repeats that must be dropped.
    key = 8'($urandom);
    acc = cyc + 1;
    push_seq(1'b0, 1'b1, acc, nx);
    push_seq(1'b0, 1'b0, nx, nx2);
    push_seq(1'b1, 1'b0, nx2, nx3);
    pulse(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    wait_drain("drain_pending");

    // Randomised sequences.
    for (int it = 0; it < 8; it++) begin
      int kind = int'($urandom_range(0, 2));
      wr_data = {$urandom, $urandom, $urandom};
      key = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      acc = cyc + 1;
      push_seq(kind == 2, kind == 1, acc, nx);
      pulse(kind != 2, kind == 1, kind == 2);
      wait_drain("drain_random");
    end

    // Reset in the middle of a write data phase with a read pending.
    acc = cyc + 1;
    push_seq(1'b0, 1'b0, acc, nx);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b0, 1'b1);
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      if (ad_sel && !wr_n) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("wait_data_phase", 72'(found), 72'd1);
    reset_n = 1'b0;
    q.delete();
    exp_rd = 72'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("midreset");
    end
    reset_n = 1'b1;
    repeat (20) tick();
    check("no_pending_after_reset", 72'(busy), 72'd0);
    check("queue_after_reset", 72'(q.size()), 72'd0);

    // Sequencer still operates after the abort.
    key = 8'($urandom);
    acc = cyc + 1;
    push_seq(1'b1, 1'b0, acc, nx);
    pulse(1'b0, 1'b0, 1'b1);
    wait_drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
